// File: rtl/lfsr_rand_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_rand_arbiter
//  Purpose  : Shares one free-running LFSR among NUM_REQ requesters. Requests
//             are served round-robin. Each served requester gets exactly one
//             value below its own bound, found by rejection sampling
//             successive LFSR outputs, with a subtract fallback after
//             MAX_TRIES samples.
//  Ports    : clock      - system clock, rising edge
//             reset      - asynchronous reset, active low
//             req        - request lines, held until the matching ack
//             bound      - per-requester exclusive upper bound, WIDTH bits each
//             lfsr_value - live LFSR output, a new value every cycle
//             ack        - one-hot, one-cycle acknowledge; rand_out valid
//             rand_out   - result; holds the last result between acks
//             grant_id   - index of the requester being served
//             busy       - high while a request is being sampled or acked
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_rand_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 11,
    parameter int MAX_TRIES = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     bound,
    input  logic [WIDTH-1:0]             lfsr_value,
    output logic [NUM_REQ-1:0]           ack,
    output logic [WIDTH-1:0]             rand_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TRY_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [TRY_W-1:0]  tries;
    logic [WIDTH-1:0]  bound_q;
    logic [WIDTH-1:0]  mask_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the
    // others, so no early loop exit is needed.
    // ------------------------------------------------------------------
    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W:0]     rr_sum;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (rr_sum >= (ID_W + 1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_W + 1)'(NUM_REQ);
            end
            if (req[rr_sum[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_sum[ID_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Mask for the picked bound: smallest all-ones value >= bound-1.
    // Bounds of 0 and 1 both give a zero mask. Each mask bit is set when
    // any bit at or above it in (bound-1) is set.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  bound_sel;
    logic [WIDTH-1:0]  bound_m1;
    logic [WIDTH-1:0]  mask_next;

    always_comb begin
        bound_sel = bound[pick_idx*WIDTH +: WIDTH];
        bound_m1  = (bound_sel == '0) ? '0 : bound_sel - 1'b1;
        mask_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask_next[i] = |(bound_m1 >> i);
        end
    end

    // ------------------------------------------------------------------
    // Sampling decision. A zero bound can never accept, so it takes the
    // fallback on its first sample (cand is 0 there, giving 0).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  cand;
    logic              cand_ok;
    logic              force_fb;
    logic [ID_W-1:0]   next_ptr;

    always_comb begin
        cand     = lfsr_value & mask_q;
        cand_ok  = (cand < bound_q);
        force_fb = (bound_q == '0) || (tries == TRY_W'(MAX_TRIES - 1));
        next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ack      <= '0;
            rand_out <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            tries    <= '0;
            bound_q  <= '0;
            mask_q   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        bound_q  <= bound_sel;
                        mask_q   <= mask_next;
                        tries    <= '0;
                        busy     <= 1'b1;
                        state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (!req[grant_id]) begin
                        // Requester gave up: no ack, result and pointer kept.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cand_ok) begin
                        rand_out <= cand;
                        ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
                        state    <= DONE;
                    end else if (force_fb) begin
                        // mask_q < 2*bound_q, so the difference is in range.
                        rand_out <= cand - bound_q;
                        ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
                        state    <= DONE;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lfsr_rand_arbiter.md
# lfsr_rand_arbiter

Shares the game's single 11-bit free-running LFSR between up to `NUM_REQ` maze-logic requesters (maze carver, item placer, enemy spawner, and so on). Each requester asks for a random number below its own bound. The block arbitrates round-robin, rejection-samples successive LFSR outputs against that bound, and returns exactly one value per request with a one-cycle acknowledge. It sits between the LFSR instance and the game FSMs; the LFSR itself is unchanged and keeps stepping every clock.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 11: LFSR and bound width.
- `MAX_TRIES`, default 8: rejected samples allowed before fallback, 1..15.
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `req`  in  `NUM_REQ`: request lines, held high until the matching `ack` is seen.
- `bound`  in  `NUM_REQ*WIDTH`: per-requester exclusive upper bound; slice i is `bound[i*WIDTH +: WIDTH]`.
- `lfsr_value`  in  `WIDTH`: LFSR `out`; a new value is presented every cycle.
- `ack`  out  `NUM_REQ`: one-hot, one-cycle pulse; result valid this cycle.
- `rand_out`  out  `WIDTH`: result, valid while any `ack` bit is high; holds the last result otherwise.
- `grant_id`  out  `clog2(NUM_REQ)`: index of the requester being served.
- `busy`  out  1: high in SAMPLE and DONE.

## Operation
- FSM states: IDLE, SAMPLE, DONE.
- IDLE:
  - If any `req` is high, pick the first set bit at or after `rr_ptr`, wrapping around.
  - Latch that requester's bound into `bound_q` and set `grant_id`.
  - Set `mask_q` to the smallest all-ones value that is ≥ `bound_q - 1`.
  - Clear `tries`, then go to SAMPLE.
- SAMPLE (one candidate per cycle), with `cand = lfsr_value & mask_q`:
  - If `cand < bound_q`: register `rand_out = cand` and go to DONE.
  - Otherwise, if `tries == MAX_TRIES-1`: fallback. Register `rand_out = cand - bound_q`, which is always `< bound_q` because `mask_q < 2*bound_q`. Go to DONE.
  - Otherwise increment `tries` and stay in SAMPLE.
- DONE:
  - Drive `ack[grant_id] = 1` for exactly one cycle.
  - Set `rr_ptr = grant_id + 1`, wrapping at `NUM_REQ`.
  - Go to IDLE.
- Boundary cases:
  - `bound = 0` or `1`: `mask_q = 0`. The first SAMPLE cycle accepts `rand_out = 0` (for `bound = 0`, `0 < 0` is false, so the fallback path is forced and returns 0).
  - `bound = 2047`: `mask_q = 2047`; only `cand = 2047` is rejected.
  - Granted `req` drops during SAMPLE: abort to IDLE. No `ack`, `rand_out` unchanged, `rr_ptr` unchanged.
  - Requests arriving while busy are not lost; they wait in IDLE arbitration.
  - Simultaneous requests: round-robin order only, no priority bias beyond `rr_ptr`.
- Reset (asynchronous, any state): state = IDLE; `ack = 0`; `rand_out = 0`; `grant_id = 0`; `busy = 0`; `rr_ptr = 0`; `tries = 0`; `bound_q = 0`; `mask_q = 0`.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Latency from `req` high (sampled in IDLE at edge N):
  - SAMPLE begins at N+1.
  - An accept on the k-th sample (k ≥ 1) gives `ack` high during cycle N+1+k.
  - Best case: `ack` in the 2nd cycle after the request edge. Worst case: `MAX_TRIES + 1` cycles.
- Requester rule: deassert `req` on the edge at which `ack` is sampled high. If `req` is still high in the following IDLE cycle, it is treated as a new request.
- Throughput: at most one result per `MAX_TRIES + 2` cycles worst case, and one per 3 cycles best case.
- `lfsr_value` is consumed live; no value is reused across SAMPLE cycles.

## Test plan
- Reset: hold `reset = 0` mid-SAMPLE, then release → all outputs 0, state IDLE, no `ack` glitch.
- Single accept: `req = 4'b0001`, bound0 = 10, bench drives `lfsr_value` 13, 12, 7 on SAMPLE cycles → masks 13, 12, 7; `ack = 4'b0001` on the 4th cycle after grant with `rand_out = 7`, `busy` low the next cycle.
- Fallback: `MAX_TRIES = 8`, bound1 = 9, `lfsr_value` held at 15 → 8 rejects, then `rand_out = 6`; `ack[1]` arrives 9 cycles after the request edge.
- Round-robin: `req = 4'b1011` held, with each requester dropping `req` after its `ack` and re-raising it two cycles later → grant order 0, 1, 3, 0, 1, 3; `ack` is never two bits at once.
- Degenerate bounds: bound = 0 → `rand_out = 0`; bound = 1 → `rand_out = 0`; bound = 2047 with `lfsr_value` 2047 then 5 → `rand_out = 5`. Each case ends with exactly one `ack`.
- Abort: drop `req[2]` during its 2nd SAMPLE cycle → no `ack[2]`, `rand_out` unchanged, next grant goes to the next pending requester starting from the unchanged `rr_ptr`.
